// File: rtl/biriscv_mul_pipe.sv
// Pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU, plus MULW at XLEN=64).
// E1 holds the extended operands, E2 the selected result, and E3..E(STAGES) are delay stages.
module biriscv_mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            opcode_valid_i,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            writeback_valid_o,
    output logic [4:0]      writeback_rd_idx_o,
    output logic [XLEN-1:0] writeback_value_o,
    output logic            busy_o
);
    localparam int unsigned NDLY = STAGES - 1;
    localparam int          WP   = 2 * XLEN + 2;

    logic [6:0]    w_opc;
    logic [6:0]    w_f7;
    logic [2:0]    w_f3;
    logic          w_is_grp;
    logic          w_is_mulw;
    logic          w_accept;
    logic          w_hi;
    logic [XLEN:0] w_a_ext;
    logic [XLEN:0] w_b_ext;

    assign w_opc     = opcode_opcode_i[6:0];
    assign w_f3      = opcode_opcode_i[14:12];
    assign w_f7      = opcode_opcode_i[31:25];
    assign w_is_grp  = (w_opc == 7'b0110011) && (w_f7 == 7'b0000001) && !w_f3[2];
    assign w_is_mulw = (XLEN == 64) && (w_opc == 7'b0111011) && (w_f7 == 7'b0000001) &&
                       (w_f3 == 3'b000);
    assign w_accept  = opcode_valid_i & (w_is_grp | w_is_mulw) & ~hold_i & ~flush_i;
    assign w_hi      = w_is_grp & (w_f3[1:0] != 2'b00);

    always_comb begin
        w_a_ext = {1'b0, opcode_ra_operand_i};
        w_b_ext = {1'b0, opcode_rb_operand_i};
        if (w_is_mulw) begin
            w_a_ext       = '0;
            w_b_ext       = '0;
            w_a_ext[31:0] = opcode_ra_operand_i[31:0];
            w_b_ext[31:0] = opcode_rb_operand_i[31:0];
        end else begin
            case (w_f3[1:0])
                2'b01: begin
                    w_a_ext = {opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i};
                    w_b_ext = {opcode_rb_operand_i[XLEN-1], opcode_rb_operand_i};
                end
                2'b10: w_a_ext = {opcode_ra_operand_i[XLEN-1], opcode_ra_operand_i};
                default: ;
            endcase
        end
    end

    logic [XLEN:0] r_e1_a;
    logic [XLEN:0] r_e1_b;
    logic          r_e1_hi;
    logic          r_e1_word;
    logic [4:0]    r_e1_rd;
    logic          r_e1_valid;

    // Non-accepted, non-held cycles load zeros so bubbles carry zero rd/value downstream.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || flush_i) begin
            r_e1_a     <= '0;
            r_e1_b     <= '0;
            r_e1_hi    <= 1'b0;
            r_e1_word  <= 1'b0;
            r_e1_rd    <= '0;
            r_e1_valid <= 1'b0;
        end else if (!hold_i) begin
            r_e1_a     <= w_accept ? w_a_ext : '0;
            r_e1_b     <= w_accept ? w_b_ext : '0;
            r_e1_hi    <= w_accept & w_hi;
            r_e1_word  <= w_accept & w_is_mulw;
            r_e1_rd    <= w_accept ? opcode_rd_idx_i : '0;
            r_e1_valid <= w_accept;
        end
    end

    logic [WP-1:0]   w_a_wide;
    logic [WP-1:0]   w_b_wide;
    logic [WP-1:0]   w_prod;
    logic [XLEN-1:0] w_res;

    assign w_a_wide = {{(XLEN + 1){r_e1_a[XLEN]}}, r_e1_a};
    assign w_b_wide = {{(XLEN + 1){r_e1_b[XLEN]}}, r_e1_b};
    assign w_prod   = w_a_wide * w_b_wide;

    always_comb begin
        w_res = w_prod[XLEN-1:0];
        if (r_e1_word) begin
            w_res       = {XLEN{w_prod[31]}};
            w_res[31:0] = w_prod[31:0];
        end else if (r_e1_hi) begin
            w_res = w_prod[2*XLEN-1:XLEN];
        end
    end

    logic            r_v   [NDLY];
    logic [4:0]      r_rd  [NDLY];
    logic [XLEN-1:0] r_val [NDLY];

    // Index 0 is E2; the last index feeds the outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || flush_i) begin
            for (int unsigned i = 0; i < NDLY; i++) begin
                r_v[i]   <= 1'b0;
                r_rd[i]  <= '0;
                r_val[i] <= '0;
            end
        end else if (!hold_i) begin
            r_v[0]   <= r_e1_valid;
            r_rd[0]  <= r_e1_rd;
            r_val[0] <= w_res;
            for (int unsigned i = 1; i < NDLY; i++) begin
                r_v[i]   <= r_v[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_val[i] <= r_val[i-1];
            end
        end
    end

    logic w_busy;
    always_comb begin
        w_busy = r_e1_valid;
        for (int unsigned i = 0; i < NDLY; i++) begin
            w_busy = w_busy | r_v[i];
        end
    end

    logic w_unused;
    assign w_unused = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7], w_prod[WP-1:2*XLEN]};

    assign writeback_valid_o  = r_v[NDLY-1];
    assign writeback_rd_idx_o = r_rd[NDLY-1];
    assign writeback_value_o  = r_val[NDLY-1];
    assign busy_o             = w_busy;
endmodule

// File: tb/tb_biriscv_mul_pipe.sv
// Bench for biriscv_mul_pipe: three instances (32b/2st, 64b/2st, 32b/3st) share one stimulus
// stream and are compared every cycle against an in-flight list model plus fixed vectors.
module tb_biriscv_mul_pipe;
    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_op;
    logic [4:0]  i_rd;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic        i_hold;
    logic        i_flush;

    logic        w0_v, w1_v, w2_v, w0_busy, w1_busy, w2_busy;
    logic [4:0]  w0_rd, w1_rd, w2_rd;
    logic [31:0] w0_val, w2_val;
    logic [63:0] w1_val;

    int n_checks = 0;
    int n_fail   = 0;

    biriscv_mul_pipe #(.XLEN(32), .STAGES(2)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_valid_i(i_valid), .opcode_opcode_i(i_op),
        .opcode_rd_idx_i(i_rd), .opcode_ra_operand_i(i_a[31:0]), .opcode_rb_operand_i(i_b[31:0]),
        .hold_i(i_hold), .flush_i(i_flush), .writeback_valid_o(w0_v), .writeback_rd_idx_o(w0_rd),
        .writeback_value_o(w0_val), .busy_o(w0_busy));

    biriscv_mul_pipe #(.XLEN(64), .STAGES(2)) u_d64 (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_valid_i(i_valid), .opcode_opcode_i(i_op),
        .opcode_rd_idx_i(i_rd), .opcode_ra_operand_i(i_a), .opcode_rb_operand_i(i_b),
        .hold_i(i_hold), .flush_i(i_flush), .writeback_valid_o(w1_v), .writeback_rd_idx_o(w1_rd),
        .writeback_value_o(w1_val), .busy_o(w1_busy));

    biriscv_mul_pipe #(.XLEN(32), .STAGES(3)) u_d3 (
        .clk_i(clk), .rst_n_i(rst_n), .opcode_valid_i(i_valid), .opcode_opcode_i(i_op),
        .opcode_rd_idx_i(i_rd), .opcode_ra_operand_i(i_a[31:0]), .opcode_rb_operand_i(i_b[31:0]),
        .hold_i(i_hold), .flush_i(i_flush), .writeback_valid_o(w2_v), .writeback_rd_idx_o(w2_rd),
        .writeback_value_o(w2_val), .busy_o(w2_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int stg[3] = '{2, 2, 3};
    int xl[3]  = '{32, 64, 32};

    typedef struct {
        int          d;
        logic [4:0]  rd;
        logic [63:0] val;
        int          cnt;
    } ent_t;
    ent_t mq[$];

    function automatic logic [31:0] mkop(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd0, opc};
    endfunction

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPW = 7'b0111011;
    localparam logic [6:0] M   = 7'b0000001;

    // -1: not a multiply; 0..3: MUL/MULH/MULHSU/MULHU; 4: MULW
    function automatic int dec(logic [31:0] op, int x);
        if (op[6:0] == OP && op[31:25] == M && !op[14]) return int'(op[13:12]);
        if (x == 64 && op[6:0] == OPW && op[31:25] == M && op[14:12] == 3'b000) return 4;
        return -1;
    endfunction

    function automatic logic [127:0] sx(logic [63:0] v, int x);
        if (x == 32) return {{96{v[31]}}, v[31:0]};
        return {{64{v[63]}}, v};
    endfunction

    function automatic logic [127:0] zx(logic [63:0] v, int x);
        if (x == 32) return {96'h0, v[31:0]};
        return {64'h0, v};
    endfunction

    function automatic logic [63:0] ref_val(int x, int op, logic [63:0] a, logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  r;
        case (op)
            0: p = zx(a, x) * zx(b, x);
            1: p = sx(a, x) * sx(b, x);
            2: p = sx(a, x) * zx(b, x);
            3: p = zx(a, x) * zx(b, x);
            default: p = {96'h0, a[31:0]} * {96'h0, b[31:0]};
        endcase
        if (op == 4) r = {{32{p[31]}}, p[31:0]};
        else if (op == 0) r = p[63:0];
        else r = 64'(p >> x);
        if (x == 32) r = {32'h0, r[31:0]};
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic get_out(input int d, output logic v, output logic [4:0] rd,
                           output logic [63:0] val, output logic b);
        case (d)
            0: begin v = w0_v; rd = w0_rd; val = {32'h0, w0_val}; b = w0_busy; end
            1: begin v = w1_v; rd = w1_rd; val = w1_val; b = w1_busy; end
            default: begin v = w2_v; rd = w2_rd; val = {32'h0, w2_val}; b = w2_busy; end
        endcase
    endtask

    task automatic check_model();
        logic        ev, eb, v, b;
        logic [4:0]  erd, rd;
        logic [63:0] eval, val;
        for (int d = 0; d < 3; d++) begin
            ev = 1'b0; eb = 1'b0; erd = '0; eval = '0;
            foreach (mq[k]) begin
                if (mq[k].d == d) begin
                    eb = 1'b1;
                    if (mq[k].cnt == stg[d]) begin
                        ev = 1'b1; erd = mq[k].rd; eval = mq[k].val;
                    end
                end
            end
            get_out(d, v, rd, val, b);
            chk($sformatf("dut%0d valid", d), {63'h0, v}, {63'h0, ev});
            chk($sformatf("dut%0d rd", d), {59'h0, rd}, {59'h0, erd});
            chk($sformatf("dut%0d value", d), val, eval);
            chk($sformatf("dut%0d busy", d), {63'h0, b}, {63'h0, eb});
        end
    endtask

    task automatic model_edge();
        ent_t nq[$];
        ent_t e;
        int   op;
        if (!rst_n || i_flush) begin
            mq.delete();
        end else if (!i_hold) begin
            foreach (mq[k]) begin
                e = mq[k];
                e.cnt++;
                if (e.cnt <= stg[e.d]) nq.push_back(e);
            end
            mq = nq;
            if (i_valid) begin
                for (int d = 0; d < 3; d++) begin
                    op = dec(i_op, xl[d]);
                    if (op >= 0) mq.push_back('{d, i_rd, ref_val(xl[d], op, i_a, i_b), 1});
                end
            end
        end
    endtask

    task automatic drive(logic v, logic [31:0] op, logic [4:0] rd, logic [63:0] a,
                         logic [63:0] b, logic h, logic f);
        i_valid = v; i_op = op; i_rd = rd; i_a = a; i_b = b; i_hold = h; i_flush = f;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_model();
    endtask

    task automatic to_next();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        at_neg();
        to_next();
    endtask

    typedef struct {
        logic [31:0] op;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [63:0] b;
        logic        v32;
        logic [31:0] e32;
        logic        v64;
        logic [63:0] e64;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 8))
            0: return mkop(M, 3'b000, OP);
            1: return mkop(M, 3'b001, OP);
            2: return mkop(M, 3'b010, OP);
            3: return mkop(M, 3'b011, OP);
            4: return mkop(M, 3'b000, OPW);
            5: return mkop(7'b0, 3'b000, OP);
            6: return mkop(M, 3'b100, OP);
            7: return mkop(M, 3'b001, OPW);
            default: return mkop(7'b0100000, 3'b000, OP);
        endcase
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        tbl[0]  = '{mkop(M, 3'b000, OP), 5'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                    1'b1, 32'hFFFF_FFEB, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1]  = '{mkop(M, 3'b001, OP), 5'd6, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
                    1'b1, 32'h4000_0000, 1'b1, 64'h0};
        tbl[2]  = '{mkop(M, 3'b010, OP), 5'd7, ONES, ONES, 1'b1, 32'hFFFF_FFFF, 1'b1, ONES};
        tbl[3]  = '{mkop(M, 3'b011, OP), 5'd8, ONES, ONES,
                    1'b1, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[4]  = '{mkop(M, 3'b000, OPW), 5'd9, 64'h0000_0001_4000_0000, 64'd2,
                    1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_8000_0000};
        tbl[5]  = '{mkop(7'b0, 3'b000, OP), 5'd10, 64'd3, 64'd4, 1'b0, 32'h0, 1'b0, 64'h0};
        tbl[6]  = '{mkop(M, 3'b000, OP), 5'd31, 64'd0, 64'd12345, 1'b1, 32'h0, 1'b1, 64'h0};
        tbl[7]  = '{mkop(M, 3'b000, OP), 5'd1, ONES, ONES, 1'b1, 32'h1, 1'b1, 64'h1};
        tbl[8]  = '{mkop(M, 3'b001, OP), 5'd2, ONES, 64'd1, 1'b1, 32'hFFFF_FFFF, 1'b1, ONES};
        tbl[9]  = '{mkop(M, 3'b011, OP), 5'd3, 64'h0000_0000_8000_0000, 64'd2,
                    1'b1, 32'h1, 1'b1, 64'h0};
        tbl[10] = '{mkop(M, 3'b100, OP), 5'd4, 64'd5, 64'd6, 1'b0, 32'h0, 1'b0, 64'h0};
        tbl[11] = '{mkop(M, 3'b010, OP), 5'd12, 64'd2, ONES, 1'b1, 32'h1, 1'b1, 64'h1};

        rst_n = 1'b0;
        idle();
        #2;
        chk("reset valid", {63'h0, w0_v}, 64'h0);
        chk("reset rd", {59'h0, w0_rd}, 64'h0);
        chk("reset value", {32'h0, w0_val}, 64'h0);
        chk("reset busy", {63'h0, w0_busy}, 64'h0);
        chk("reset value64", w1_val, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cyc();

        // isolated MUL: single pulse two cycles after issue
        drive(1'b1, mkop(M, 3'b000, OP), 5'd5, 64'd7, 64'hFFFF_FFFD, 1'b0, 1'b0);
        at_neg(); to_next();
        idle();
        at_neg(); chk("iso c1 valid", {63'h0, w0_v}, 64'h0); chk("iso c1 value", {32'h0, w0_val}, 64'h0); to_next();
        at_neg(); chk("iso c2 valid", {63'h0, w0_v}, 64'h1); chk("iso c2 rd", {59'h0, w0_rd}, 64'd5);
        chk("iso c2 value", {32'h0, w0_val}, 64'hFFFF_FFEB); to_next();
        at_neg(); chk("iso c3 valid", {63'h0, w0_v}, 64'h0); chk("iso c3 value", {32'h0, w0_val}, 64'h0); to_next();
        repeat (2) cyc();

        // back-to-back table vectors
        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive(1'b1, tbl[i].op, tbl[i].rd, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
            else idle();
            at_neg();
            if (i >= 2) begin
                chk($sformatf("tbl%0d v32", i - 2), {63'h0, w0_v}, {63'h0, tbl[i-2].v32});
                chk($sformatf("tbl%0d rd32", i - 2), {59'h0, w0_rd}, tbl[i-2].v32 ? {59'h0, tbl[i-2].rd} : 64'h0);
                chk($sformatf("tbl%0d val32", i - 2), {32'h0, w0_val}, {32'h0, tbl[i-2].e32});
                chk($sformatf("tbl%0d v64", i - 2), {63'h0, w1_v}, {63'h0, tbl[i-2].v64});
                chk($sformatf("tbl%0d val64", i - 2), w1_val, tbl[i-2].e64);
            end
            to_next();
        end
        repeat (2) cyc();

        // hold on the 3-stage instance: issue in cycle 0, hold cycles 1..3
        drive(1'b1, mkop(M, 3'b000, OP), 5'd9, 64'd3, 64'd4, 1'b0, 1'b0);
        at_neg(); to_next();
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) drive(1'b1, mkop(7'b0, 3'b000, OP), 5'd10, 64'd1, 64'd1, 1'b1, 1'b0);
            else if (c <= 3) drive(1'b1, mkop(M, 3'b000, OP), 5'd11, 64'd5, 64'd5, 1'b1, 1'b0);
            else idle();
            at_neg();
            chk($sformatf("hold c%0d valid", c), {63'h0, w2_v}, (c == 6) ? 64'h1 : 64'h0);
            chk($sformatf("hold c%0d value", c), {32'h0, w2_val}, (c == 6) ? 64'd12 : 64'h0);
            chk($sformatf("hold c%0d rd", c), {59'h0, w2_rd}, (c == 6) ? 64'd9 : 64'h0);
            to_next();
        end
        repeat (2) cyc();

        // flush in cycle 2 alongside a third MUL; issue resumes in cycle 3
        drive(1'b1, mkop(M, 3'b000, OP), 5'd1, 64'd5, 64'd6, 1'b0, 1'b0);
        at_neg(); to_next();
        drive(1'b1, mkop(M, 3'b000, OP), 5'd2, 64'd7, 64'd8, 1'b0, 1'b0);
        at_neg(); to_next();
        drive(1'b1, mkop(M, 3'b000, OP), 5'd3, 64'd9, 64'd9, 1'b0, 1'b1);
        at_neg(); chk("flush c2 valid", {63'h0, w0_v}, 64'h1); chk("flush c2 value", {32'h0, w0_val}, 64'd30); to_next();
        drive(1'b1, mkop(M, 3'b000, OP), 5'd4, 64'd2, 64'd3, 1'b0, 1'b0);
        at_neg(); chk("flush c3 valid", {63'h0, w0_v}, 64'h0); chk("flush c3 busy", {63'h0, w0_busy}, 64'h0);
        chk("flush c3 busy3", {63'h0, w2_busy}, 64'h0); to_next();
        idle();
        at_neg(); chk("flush c4 valid", {63'h0, w0_v}, 64'h0); to_next();
        at_neg(); chk("flush c5 valid", {63'h0, w0_v}, 64'h1); chk("flush c5 value", {32'h0, w0_val}, 64'd6);
        chk("flush c5 rd", {59'h0, w0_rd}, 64'd4); to_next();
        repeat (3) cyc();

        // asynchronous reset while a MUL sits in E1
        drive(1'b1, mkop(M, 3'b000, OP), 5'd6, 64'd7, 64'd7, 1'b0, 1'b0);
        at_neg(); to_next();
        idle();
        #2;
        chk("pre-reset busy", {63'h0, w0_busy}, 64'h1);
        rst_n = 1'b0;
        mq.delete();
        #1;
        chk("async rst busy", {63'h0, w0_busy}, 64'h0);
        chk("async rst valid", {63'h0, w0_v}, 64'h0);
        chk("async rst busy3", {63'h0, w2_busy}, 64'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk($sformatf("post-rst c%0d valid", c), {63'h0, w0_v}, 64'h0);
            chk($sformatf("post-rst c%0d busy", c), {63'h0, w0_busy}, 64'h0);
            to_next();
        end

        // randomized traffic against the in-flight model
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 7), rand_op(), 5'($urandom_range(0, 31)),
                  rand_operand(), rand_operand(),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
            cyc();
        end
        idle();
        repeat (5) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
